store_rmw_unit: RTL and testbench

//  Register-to-memory store path; the counterpart of the memory-to-register writeback select.

---
 rtl/store_pkg.sv | 33 +++
 rtl/store_rmw_unit_if.sv | 28 ++
 rtl/store_merge.sv | 29 ++
 rtl/store_rmw_unit.sv | 100 ++++++++++
 tb/tb_store_rmw_unit.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/store_pkg.sv
// Shared types for the register-to-memory store path.
// Size codes, FSM states and read-latency bounds.
package store_pkg;

    localparam int DATA_W  = 32;
    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 3;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_BYTE = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        MG   = 3'd2,
        WR   = 3'd3,
        DN   = 3'd4,
        ERR  = 3'd5
    } state_e;

    // Misaligned word/half or the reserved size code.
    function automatic logic req_bad(
        input logic [1:0] size,
        input logic [1:0] off
    );
        return (size == SZ_WORD && off != 2'd0)
            || (size == SZ_HALF && off[0])
            || (size == SZ_RSVD);
    endfunction

endpackage

// File: rtl/store_rmw_unit_if.sv
// Control-side request and data-memory bus of the store unit.
// master = control/memory side, slave = store unit.
interface store_rmw_unit_if;
    import store_pkg::*;

    logic              start;
    logic [1:0]        store_size;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] B_out;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              busy;
    logic              done;
    logic              align_err;

    modport master (
        output start, store_size, addr, B_out, mem_rdata,
        input  mem_addr, mem_wdata, mem_we, busy, done, align_err
    );

    modport slave (
        input  start, store_size, addr, B_out, mem_rdata,
        output mem_addr, mem_wdata, mem_we, busy, done, align_err
    );

endinterface

// File: rtl/store_merge.sv
// Lane merge: drops the low byte/half of data_i into word_i
// at the lane picked by offset_i; a word store takes data_i whole.
module store_merge
    import store_pkg::*;
(
    input  logic [DATA_W-1:0] word_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [1:0]        size_i,
    input  logic [1:0]        offset_i,
    output logic [DATA_W-1:0] word_o
);

    logic [4:0] byte_lsb;
    logic [4:0] half_lsb;

    assign byte_lsb = {offset_i, 3'b000};
    assign half_lsb = {offset_i[1], 4'b0000};

    always_comb begin
        word_o = word_i;
        case (size_i)
            SZ_WORD: word_o = data_i;
            SZ_HALF: word_o[half_lsb +: 16] = data_i[15:0];
            SZ_BYTE: word_o[byte_lsb +: 8]  = data_i[7:0];
            default: word_o = word_i;
        endcase
    end

endmodule

// File: rtl/store_rmw_unit.sv
// Store path for sw/sh/sb: word stores write directly,
// half/byte stores read the word, merge the lanes, then write.
module store_rmw_unit
    import store_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input logic             clk,
    input logic             reset,
    store_rmw_unit_if.slave bus
);

    localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [1:0]        size_q, size_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] merged;

    store_merge u_merge (
        .word_i   (rdata_q),
        .data_i   (data_q),
        .size_i   (size_q),
        .offset_i (addr_q[1:0]),
        .word_o   (merged)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            size_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    size_d = bus.store_size;
                    addr_d = bus.addr;
                    data_d = bus.B_out;
                    if (req_bad(bus.store_size, bus.addr[1:0])) begin
                        state_d = ERR;
                    end else if (bus.store_size == SZ_WORD) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            // mem_addr is held while the memory read is in flight
            RD: begin
                if (cnt_q == 2'd0) begin
                    state_d = MG;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            MG: begin
                rdata_d = bus.mem_rdata;
                state_d = WR;
            end
            WR:      state_d = DN;
            DN:      state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Decoded straight from the state so reset clears them at once.
    assign bus.mem_addr  = {addr_q[DATA_W-1:2], 2'b00};
    assign bus.mem_wdata = merged;
    assign bus.mem_we    = (state_q == WR);
    assign bus.busy      = (state_q == RD) || (state_q == MG)
                        || (state_q == WR);
    assign bus.done      = (state_q == DN) || (state_q == ERR);
    assign bus.align_err = (state_q == ERR);

endmodule

// File: tb/tb_store_rmw_unit.sv
// Bench for store_rmw_unit: directed cases plus random stores
// against a byte-level memory model.
module tb_store_rmw_unit;
    import store_pkg::*;

    localparam int LAT = 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    store_rmw_unit_if bus ();

    store_rmw_unit #(.MEM_LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem [64];
    logic [31:0] pipe [LAT];
    logic        poke_en = 1'b0;
    logic [5:0]  poke_idx = '0;
    logic [31:0] poke_val = '0;

    always @(posedge clk) begin
        if (poke_en) mem[poke_idx] <= poke_val;
        else if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
        pipe[0] <= mem[bus.mem_addr[7:2]];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.mem_rdata = pipe[LAT-1];

    logic [31:0] ref_mem [64];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] old,
        input logic [31:0] d, input logic [1:0] sz, input logic [31:0] a);
        logic [7:0] b [4];
        int lane;
        lane = int'(a % 4);
        for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
        if (sz == 2'd0) begin
            for (int i = 0; i < 4; i++) b[i] = d[8*i +: 8];
        end else if (sz == 2'd1) begin
            b[lane - lane % 2]     = d[7:0];
            b[lane - lane % 2 + 1] = d[15:8];
        end else if (sz == 2'd2) begin
            b[lane] = d[7:0];
        end
        return {b[3], b[2], b[1], b[0]};
    endfunction

    function automatic bit is_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd0 && a % 4 != 0)
            || (sz == 2'd1 && a % 2 != 0);
    endfunction

    task automatic poke(input int idx, input logic [31:0] val);
        @(negedge clk);
        poke_en  = 1'b1;
        poke_idx = 6'(idx);
        poke_val = val;
        ref_mem[idx] = val;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic store(input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] d, input bit pulse_busy,
                         input bit pulse_done, input string tag);
        bit err = is_err(sz, a);
        int idx = int'(a[7:2]);
        logic [31:0] exp_addr = {a[31:2], 2'b00};
        logic [31:0] exp_w = model_word(ref_mem[idx], d, sz, a);
        int exp_done = err ? 1 : (sz == 2'd0 ? 2 : 3 + LAT);
        int exp_we = exp_done - 1;
        int n = 0;
        int we_cnt = 0;
        int we_at = 0;
        int done_at = 0;
        bit busy_ok = 1'b1;
        bit addr_ok = 1'b1;
        logic err_seen = 1'b0;
        logic [31:0] w_seen = '0;
        logic [31:0] a_seen = '0;
        @(negedge clk);
        bus.start      = 1'b1;
        bus.store_size = sz;
        bus.addr       = a;
        bus.B_out      = d;
        while (done_at == 0 && n < 20) begin
            @(negedge clk);
            n++;
            if (bus.mem_we) begin
                we_cnt++;
                we_at  = n;
                w_seen = bus.mem_wdata;
                a_seen = bus.mem_addr;
            end
            if (bus.done) begin
                done_at  = n;
                err_seen = bus.align_err;
                if (bus.busy) busy_ok = 1'b0;
            end else begin
                if (!bus.busy || bus.align_err) busy_ok = 1'b0;
                if (!err && bus.mem_addr !== exp_addr) addr_ok = 1'b0;
            end
            bus.start      = (bus.done && pulse_done)
                          || (!bus.done && pulse_busy && n == 1);
            bus.store_size = 2'($urandom);
            bus.addr       = $urandom;
            bus.B_out      = $urandom;
        end
        check({tag, ".done_cycle"}, 32'(done_at), 32'(exp_done));
        check({tag, ".we_count"}, 32'(we_cnt), err ? 32'd0 : 32'd1);
        check({tag, ".align_err"}, {31'd0, err_seen}, {31'd0, err});
        check({tag, ".busy_ok"}, {31'd0, busy_ok}, 32'd1);
        if (!err) begin
            check({tag, ".we_cycle"}, 32'(we_at), 32'(exp_we));
            check({tag, ".wdata"}, w_seen, exp_w);
            check({tag, ".mem_addr"}, a_seen, exp_addr);
            check({tag, ".addr_stable"}, {31'd0, addr_ok}, 32'd1);
            ref_mem[idx] = exp_w;
        end
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, ".idle_after"},
              {29'd0, bus.busy, bus.done, bus.mem_we}, 32'd0);
    endtask

    task automatic reset_mid_op();
        int we_cnt = 0;
        @(negedge clk);
        bus.start      = 1'b1;
        bus.store_size = SZ_BYTE;
        bus.addr       = 32'h42;
        bus.B_out      = 32'h5A;
        repeat (LAT + 1) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.mem_we) we_cnt++;
        end
        reset = 1'b0;
        #1;
        check("rst.we_before", 32'(we_cnt), 32'd0);
        check("rst.flags", {28'd0, bus.mem_we, bus.busy, bus.done,
              bus.align_err}, 32'd0);
        check("rst.mem_addr", bus.mem_addr, 32'd0);
        check("rst.mem_wdata", bus.mem_wdata, 32'd0);
        @(negedge clk);
        check("rst.held", {28'd0, bus.mem_we, bus.busy, bus.done,
              bus.align_err}, 32'd0);
        reset = 1'b1;
        store(SZ_WORD, 32'h80, 32'h0BAD_F00D, 1'b0, 1'b0, "rst.sw");
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.store_size = '0;
        bus.addr       = '0;
        bus.B_out      = '0;
        #1;
        check("reset.flags", {28'd0, bus.mem_we, bus.busy, bus.done,
              bus.align_err}, 32'd0);
        check("reset.mem_addr", bus.mem_addr, 32'd0);
        check("reset.mem_wdata", bus.mem_wdata, 32'd0);
        for (int i = 0; i < 64; i++)
            poke(i, 32'(i) * 32'h9E37_79B9 ^ 32'hA5A5_0F0F);
        @(negedge clk);
        reset = 1'b1;

        store(SZ_WORD, 32'h40, 32'hDEAD_BEEF, 1'b0, 1'b0, "sw");
        check("sw.wdata_abs", ref_mem[16], 32'hDEAD_BEEF);
        poke(16, 32'h1122_3344);
        store(SZ_BYTE, 32'h42, 32'h0000_00AB, 1'b0, 1'b0, "sb");
        check("sb.wdata_abs", ref_mem[16], 32'h11AB_3344);
        poke(17, 32'h5566_7788);
        store(SZ_HALF, 32'h46, 32'h0000_CAFE, 1'b0, 1'b0, "sh");
        check("sh.wdata_abs", ref_mem[17], 32'hCAFE_7788);
        store(SZ_HALF, 32'h41, 32'h1234_5678, 1'b0, 1'b1, "sh_mis");
        store(SZ_WORD, 32'h43, 32'h1234_5678, 1'b0, 1'b1, "sw_mis");
        store(SZ_RSVD, 32'h48, 32'h1234_5678, 1'b0, 1'b0, "rsvd");
        store(SZ_BYTE, 32'h51, 32'h0000_0077, 1'b1, 1'b1, "sb_poke");

        reset_mid_op();

        for (int t = 0; t < 150; t++) begin
            store(2'($urandom_range(0, 3)), $urandom, $urandom,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  "rand");
        end

        @(negedge clk);
        for (int i = 0; i < 64; i++) check("mem_final", mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
